// File: rtl/ifw_pkg.sv
// Shared definitions for the ifmap write path: ifw state encodings,
// master-state labels and default counter widths.
package ifw_pkg;

  typedef enum logic [1:0] {
    IFW_IDLE = 2'd0,
    IFW_FILL = 2'd1,
    IFW_WAIT = 2'd2,
    IFW_DONE = 2'd3
  } ifw_state_t;

  typedef enum logic [1:0] {
    MAST_NORMAL = 2'd1,
    MAST_LEFT   = 2'd2,
    MAST_RIGH   = 2'd3
  } cfg_mast_state_t;

  localparam int DEF_CNT00_WIDTH = 10;
  localparam int DEF_CNT01_WIDTH = 10;
  localparam int DEF_ROW_WIDTH   = 10;

endpackage

// File: rtl/count_yi_v4.sv
// Enable-gated counter that wraps at an inclusive final value instead of
// at 2^WIDTH; last is high while the count equals the final value.
module count_yi_v4 #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] final_val,
  output logic             last
);

  logic [WIDTH-1:0] cnt;

  assign last = (cnt == final_val);

  always_ff @(posedge clk) begin
    if (reset || clear)
      cnt <= '0;
    else if (en)
      cnt <= last ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/ifw_pingpong_sched.sv
// Ping-pong write scheduler steering input beats into two ifmap buffers.
// Optional stall counter port perf_stall_cnt is built when IFW_SCHED_PERF_EN is defined.
module ifw_pingpong_sched
  import ifw_pkg::*;
#(
  parameter int CNT00_WIDTH = DEF_CNT00_WIDTH,
  parameter int CNT01_WIDTH = DEF_CNT01_WIDTH,
  parameter int ROW_WIDTH   = DEF_ROW_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_start,
  input  logic [CNT00_WIDTH-1:0] cfg_cnt00_final,
  input  logic [CNT01_WIDTH-1:0] cfg_cnt01_final,
  input  logic [ROW_WIDTH-1:0]   cfg_row_final,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [1:0]             buf_rd_done,
  output logic                   wr_buf_sel,
  output logic [1:0]             wr_stg0_en,
  output logic [1:0]             wr_stg1_en,
  output logic [1:0]             buf_full,
  output logic                   row_last,
  output logic [1:0]             ifw_state,
  output logic                   done
`ifdef IFW_SCHED_PERF_EN
  ,
  output logic [31:0]            perf_stall_cnt
`endif
);

  ifw_state_t state, state_nxt;

  logic [CNT00_WIDTH-1:0] cnt00_final;
  logic [CNT01_WIDTH-1:0] cnt01_final;
  logic [ROW_WIDTH-1:0]   row_final;
  logic                   start, accept, row_complete;
  logic                   cnt00_last, cnt01_last, row_cnt_last;
  logic [1:0]             buf_full_nxt;

  assign start        = (state == IFW_IDLE) && cfg_start;
  assign accept       = s_valid && s_ready;
  assign row_complete = accept && cnt00_last && cnt01_last;
  assign row_last     = (state != IFW_IDLE) && row_cnt_last;
  assign ifw_state    = state;

  count_yi_v4 #(.WIDTH(CNT00_WIDTH)) u_cnt00 (
    .clk(clk), .reset(reset), .clear(start), .en(accept),
    .final_val(cnt00_final), .last(cnt00_last)
  );

  count_yi_v4 #(.WIDTH(CNT01_WIDTH)) u_cnt01 (
    .clk(clk), .reset(reset), .clear(start), .en(accept && cnt00_last),
    .final_val(cnt01_final), .last(cnt01_last)
  );

  // The row counter holds on the final row so row_last stays up through DONE.
  count_yi_v4 #(.WIDTH(ROW_WIDTH)) u_row (
    .clk(clk), .reset(reset), .clear(start), .en(row_complete && !row_cnt_last),
    .final_val(row_final), .last(row_cnt_last)
  );

  // A row-complete set beats a same-cycle read-side clear.
  always_comb begin
    for (int i = 0; i < 2; i++)
      buf_full_nxt[i] = (row_complete && (wr_buf_sel == 1'(i))) ||
                        (buf_full[i] && !buf_rd_done[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IFW_IDLE;
      buf_full    <= 2'b00;
      wr_buf_sel  <= 1'b0;
      done        <= 1'b0;
      cnt00_final <= '0;
      cnt01_final <= '0;
      row_final   <= '0;
    end else begin
      state    <= state_nxt;
      buf_full <= buf_full_nxt;
      done     <= (state == IFW_DONE);
      if (start) begin
        cnt00_final <= cfg_cnt00_final;
        cnt01_final <= cfg_cnt01_final;
        row_final   <= cfg_row_final;
        wr_buf_sel  <= buf_full[0] && !buf_full[1];
      end else if (row_complete && !row_cnt_last) begin
        wr_buf_sel <= !wr_buf_sel;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IFW_IDLE:
        if (cfg_start)
          state_nxt = (&buf_full) ? IFW_WAIT : IFW_FILL;
      IFW_FILL:
        if (row_complete) begin
          if (row_cnt_last)
            state_nxt = IFW_DONE;
          else
            state_nxt = buf_full_nxt[!wr_buf_sel] ? IFW_WAIT : IFW_FILL;
        end
      IFW_WAIT:
        if (!buf_full[wr_buf_sel])
          state_nxt = IFW_FILL;
      IFW_DONE:
        state_nxt = IFW_IDLE;
      default:
        state_nxt = IFW_IDLE;
    endcase
  end

  always_comb begin
    s_ready    = 1'b0;
    wr_stg0_en = 2'b00;
    wr_stg1_en = 2'b00;
    if (state == IFW_FILL)
      s_ready = !buf_full[wr_buf_sel];
    if (accept) begin
      wr_stg0_en[wr_buf_sel] = 1'b1;
      if (cnt00_last)
        wr_stg1_en[wr_buf_sel] = 1'b1;
    end
  end

`ifdef IFW_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || cfg_start)
      perf_stall_cnt <= '0;
    else if (s_valid && !s_ready && (state != IFW_IDLE) && (perf_stall_cnt != '1))
      perf_stall_cnt <= perf_stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_ifw_pingpong_sched.sv
// Directed self-checking bench for ifw_pingpong_sched (stall counter checks
// are included when IFW_SCHED_PERF_EN is defined).
module tb_ifw_pingpong_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_start;
  logic [9:0] cfg_cnt00_final, cfg_cnt01_final, cfg_row_final;
  logic       s_valid;
  logic       s_ready;
  logic [1:0] buf_rd_done;
  logic       wr_buf_sel;
  logic [1:0] wr_stg0_en, wr_stg1_en, buf_full;
  logic       row_last;
  logic [1:0] ifw_state;
  logic       done;
`ifdef IFW_SCHED_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ifw_pingpong_sched dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start),
    .cfg_cnt00_final(cfg_cnt00_final), .cfg_cnt01_final(cfg_cnt01_final),
    .cfg_row_final(cfg_row_final), .s_valid(s_valid), .s_ready(s_ready),
    .buf_rd_done(buf_rd_done), .wr_buf_sel(wr_buf_sel),
    .wr_stg0_en(wr_stg0_en), .wr_stg1_en(wr_stg1_en), .buf_full(buf_full),
    .row_last(row_last), .ifw_state(ifw_state), .done(done)
`ifdef IFW_SCHED_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic valid, input logic [1:0] rd_done);
    cfg_start   = start;
    s_valid     = valid;
    buf_rd_done = rd_done;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_state"}, 32'(ifw_state), 0);
    checkOutput({tag, "_sel"}, 32'(wr_buf_sel), 0);
    checkOutput({tag, "_full"}, 32'(buf_full), 0);
    checkOutput({tag, "_ready"}, 32'(s_ready), 0);
    checkOutput({tag, "_stg0"}, 32'(wr_stg0_en), 0);
    checkOutput({tag, "_stg1"}, 32'(wr_stg1_en), 0);
    checkOutput({tag, "_rowlast"}, 32'(row_last), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
`ifdef IFW_SCHED_PERF_EN
    checkOutput({tag, "_perf"}, perf_stall_cnt, 0);
`endif
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    cfg_start = 1'b0; s_valid = 1'b0; buf_rd_done = 2'b00;
    cfg_cnt00_final = '0; cfg_cnt01_final = '0; cfg_row_final = '0;
    tick(); tick(); #2;
    checkResetValues("reset");
    reset = 1'b0;

    // Basic run: 4x2 beats per row, two rows, buf0 then buf1.
    cfg_cnt00_final = 10'd3; cfg_cnt01_final = 10'd1; cfg_row_final = 10'd1;
    applyStimulus(1'b1, 1'b0, 2'b00);
    tick();
    applyStimulus(1'b0, 1'b1, 2'b00);
    checkOutput("basic_state_fill", 32'(ifw_state), 1);
    checkOutput("basic_ready", 32'(s_ready), 1);
    checkOutput("basic_sel0", 32'(wr_buf_sel), 0);
    for (int k = 1; k <= 16; k++) begin
      if (k == 9) begin
        checkOutput("basic_full_row0", 32'(buf_full), 2'b01);
        checkOutput("basic_rowlast_row1", 32'(row_last), 1);
        checkOutput("basic_sel1", 32'(wr_buf_sel), 1);
      end
      checkOutput($sformatf("basic_stg0_b%0d", k), 32'(wr_stg0_en), (k <= 8) ? 2'b01 : 2'b10);
      checkOutput($sformatf("basic_stg1_b%0d", k), 32'(wr_stg1_en),
                  (k % 4 != 0) ? 2'b00 : ((k <= 8) ? 2'b01 : 2'b10));
      tick();
    end
    checkOutput("basic_state_done", 32'(ifw_state), 3);
    checkOutput("basic_done_ready", 32'(s_ready), 0);
    checkOutput("basic_done_stg0", 32'(wr_stg0_en), 0);
    checkOutput("basic_full_both", 32'(buf_full), 2'b11);
    checkOutput("basic_done_rowlast", 32'(row_last), 1);
    applyStimulus(1'b0, 1'b0, 2'b00);
    tick();
    checkOutput("basic_idle", 32'(ifw_state), 0);
    checkOutput("basic_done_pulse", 32'(done), 1);
    checkOutput("basic_idle_rowlast", 32'(row_last), 0);
    tick();
    checkOutput("basic_done_clear", 32'(done), 0);

    // Back-pressure: free buf0, fill it, then wait on a full buf1.
    applyStimulus(1'b0, 1'b0, 2'b01);
    tick();
    checkOutput("bp_full_idle", 32'(buf_full), 2'b10);
    cfg_cnt00_final = 10'd1; cfg_cnt01_final = 10'd0; cfg_row_final = 10'd3;
    applyStimulus(1'b1, 1'b0, 2'b00);
    tick();
    checkOutput("bp_state_fill", 32'(ifw_state), 1);
    checkOutput("bp_sel0", 32'(wr_buf_sel), 0);
    applyStimulus(1'b0, 1'b1, 2'b00);
    checkOutput("bp_b1_stg0", 32'(wr_stg0_en), 2'b01);
    checkOutput("bp_b1_stg1", 32'(wr_stg1_en), 2'b00);
    tick();
    checkOutput("bp_b2_stg0", 32'(wr_stg0_en), 2'b01);
    checkOutput("bp_b2_stg1", 32'(wr_stg1_en), 2'b01);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("bp_state_wait", 32'(ifw_state), 2);
    checkOutput("bp_wait_sel", 32'(wr_buf_sel), 1);
    checkOutput("bp_wait_full", 32'(buf_full), 2'b11);
    checkOutput("bp_wait_ready", 32'(s_ready), 0);
    checkOutput("bp_wait_rowlast", 32'(row_last), 0);
    applyStimulus(1'b0, 1'b0, 2'b01);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("bp_clr_other_full", 32'(buf_full), 2'b10);
    checkOutput("bp_clr_other_state", 32'(ifw_state), 2);
    tick();
    checkOutput("bp_still_wait", 32'(ifw_state), 2);
    checkOutput("bp_still_ready", 32'(s_ready), 0);
    applyStimulus(1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_stall_ready_%0d", i), 32'(s_ready), 0);
      checkOutput($sformatf("bp_stall_stg0_%0d", i), 32'(wr_stg0_en), 0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 2'b00);
`ifdef IFW_SCHED_PERF_EN
    checkOutput("perf_stall_5", perf_stall_cnt, 5);
`endif
    applyStimulus(1'b0, 1'b0, 2'b10);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("bp_rel_full", 32'(buf_full), 2'b00);
    checkOutput("bp_rel_ready_c1", 32'(s_ready), 0);
    checkOutput("bp_rel_state_c1", 32'(ifw_state), 2);
    tick();
    checkOutput("bp_rel_state_c2", 32'(ifw_state), 1);
    checkOutput("bp_rel_ready_c2", 32'(s_ready), 1);
    checkOutput("bp_rel_sel", 32'(wr_buf_sel), 1);

    // Clear/set collision on buf1 at its row complete.
    applyStimulus(1'b0, 1'b1, 2'b00);
    checkOutput("col_b1_stg0", 32'(wr_stg0_en), 2'b10);
    tick();
    applyStimulus(1'b0, 1'b1, 2'b10);
    checkOutput("col_b2_stg1", 32'(wr_stg1_en), 2'b10);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("col_full_set_wins", 32'(buf_full), 2'b10);
    checkOutput("col_state", 32'(ifw_state), 1);
    checkOutput("col_sel", 32'(wr_buf_sel), 0);
    checkOutput("col_rowlast", 32'(row_last), 0);

    // Zero finals: every accept completes a row.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("zf_reset_full", 32'(buf_full), 0);
    checkOutput("zf_reset_state", 32'(ifw_state), 0);
    cfg_cnt00_final = 10'd0; cfg_cnt01_final = 10'd0; cfg_row_final = 10'd1;
    applyStimulus(1'b1, 1'b0, 2'b00);
    tick();
    applyStimulus(1'b0, 1'b1, 2'b00);
    checkOutput("zf_b1_stg0", 32'(wr_stg0_en), 2'b01);
    checkOutput("zf_b1_stg1", 32'(wr_stg1_en), 2'b01);
    tick();
    checkOutput("zf_b2_full", 32'(buf_full), 2'b01);
    checkOutput("zf_b2_sel", 32'(wr_buf_sel), 1);
    checkOutput("zf_b2_rowlast", 32'(row_last), 1);
    checkOutput("zf_b2_stg0", 32'(wr_stg0_en), 2'b10);
    checkOutput("zf_b2_stg1", 32'(wr_stg1_en), 2'b10);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("zf_state_done", 32'(ifw_state), 3);
    checkOutput("zf_full_both", 32'(buf_full), 2'b11);
    tick();
    checkOutput("zf_done_pulse", 32'(done), 1);
    checkOutput("zf_idle", 32'(ifw_state), 0);

    // Reset mid-row after 2 of 4 beats, with buf1 still full.
    applyStimulus(1'b0, 1'b0, 2'b01);
    tick();
    cfg_cnt00_final = 10'd3; cfg_cnt01_final = 10'd0; cfg_row_final = 10'd0;
    applyStimulus(1'b1, 1'b0, 2'b00);
    tick();
    applyStimulus(1'b0, 1'b1, 2'b00);
    checkOutput("rst_b1_stg0", 32'(wr_stg0_en), 2'b01);
    tick();
    checkOutput("rst_b2_stg0", 32'(wr_stg0_en), 2'b01);
    checkOutput("rst_b2_stg1", 32'(wr_stg1_en), 2'b00);
    tick();
    reset = 1'b1;
    tick();
    checkResetValues("rst_mid");
    tick();
    checkOutput("rst_hold_stg0", 32'(wr_stg0_en), 0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'b00);
    tick();
    applyStimulus(1'b0, 1'b1, 2'b00);
    for (int k = 1; k <= 4; k++) begin
      checkOutput($sformatf("rst_fresh_stg1_b%0d", k), 32'(wr_stg1_en), (k == 4) ? 2'b01 : 2'b00);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("rst_fresh_done", 32'(ifw_state), 3);
    checkOutput("rst_fresh_full", 32'(buf_full), 2'b01);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifw_pingpong_sched.md
# ifw_pingpong_sched

Ping-pong write scheduler for the ifmap write path. It accepts input beats through a valid/ready handshake and steers each beat to one of two ifmap write buffers by driving that buffer's stage-0/stage-1 counter enables. It tracks row completion, holds per-buffer full flags that the read side clears, and exports the 2-bit ifw state and row-last flag consumed by the per-buffer write FSMs.

## Interface
- CNT00_WIDTH, 10, width of the beat-in-stage-0 counter and its final number
- CNT01_WIDTH, 10, width of the stage-1 counter and its final number
- ROW_WIDTH, 10, width of the row counter and its final number
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high (reset reset, clock clk)
- cfg_start  in  1  one-cycle pulse; starts a layer when in IDLE, ignored otherwise
- cfg_cnt00_final  in  CNT00_WIDTH  stage-0 final count, inclusive; latched at start
- cfg_cnt01_final  in  CNT01_WIDTH  stage-1 final count, inclusive; latched at start
- cfg_row_final  in  ROW_WIDTH  index of the last row, inclusive; latched at start
- s_valid  in  1  input beat valid
- s_ready  out  1  scheduler can accept a beat
- buf_rd_done  in  2  per-buffer release pulse from the read side
- wr_buf_sel  out  1  buffer currently targeted
- wr_stg0_en  out  2  per-buffer stage-0 enable, one-hot or zero
- wr_stg1_en  out  2  per-buffer stage-1 enable, one-hot or zero
- buf_full  out  2  per-buffer full flags
- row_last  out  1  current row is the last row of the layer
- ifw_state  out  2  0 IDLE, 1 FILL, 2 WAIT, 3 DONE
- done  out  1  one-cycle pulse on leaving DONE

## Operation
- accept = s_valid & s_ready.
- IDLE: on cfg_start, latch the cfg values, clear all counters, and set wr_buf_sel to the lowest-index non-full buffer.
  - Next state is FILL if a non-full buffer exists, otherwise WAIT.
- FILL: s_ready = ~buf_full[wr_buf_sel].
  - Each accept pulses wr_stg0_en[wr_buf_sel] and advances cnt00.
  - When cnt00 == cnt00_final on an accept:
    - cnt00 wraps to 0.
    - wr_stg1_en[wr_buf_sel] pulses in the same cycle.
    - cnt01 advances.
- Row complete = accept & cnt00 final & cnt01 final. On row complete:
  - cnt01 wraps to 0.
  - buf_full[wr_buf_sel] is set.
  - If row_last: go to DONE.
  - Otherwise: row counter advances, wr_buf_sel toggles, and the next state is FILL if the other buffer is free (buf_full[~sel] after this cycle's clears), else WAIT.
- WAIT: s_ready = 0 and no enables. Go to FILL in the cycle after buf_full[wr_buf_sel] reads 0.
- DONE: s_ready = 0 for one cycle, then IDLE with done pulsed.
- row_last = (row_cnt == row_final) while in FILL, WAIT or DONE; 0 in IDLE.
- buf_rd_done[i] clears buf_full[i]. If a set and a clear hit the same buffer in the same cycle, the set wins.
- Full flags persist across IDLE; only reset or buf_rd_done clears them.
- All counters wrap at their final value, not at 2^WIDTH. A final value of 0 means every accept is a wrap.
- cfg inputs are sampled only in IDLE on cfg_start; later changes have no effect.

## Timing
- Reset values:
  - ifw_state 0, wr_buf_sel 0, buf_full 2'b00.
  - s_ready 0, all enables 0, row_last 0, done 0.
  - All counters 0.
- s_ready depends only on registered state and buf_full; there is no combinational path from s_valid.
- Enables are combinational from accept, in the same cycle as the beat, so the downstream counters update on the next edge.
- Latencies:
  - cfg_start to first possible accept: 1 cycle.
  - Row complete to first accept on the alternate free buffer: 1 cycle.
  - buf_rd_done to s_ready in WAIT: 2 cycles (flag clears, then state moves to FILL).
- Reset mid-operation returns to IDLE in 1 cycle and discards the partial row and full flags.

## Configuration
- IFW_SCHED_PERF_EN defined:
  - Adds output perf_stall_cnt[31:0], counting cycles with s_valid & ~s_ready & (ifw_state != IDLE).
  - It saturates at all-ones, clears on reset and on cfg_start.
- Undefined: the port and counter are absent.

## Structure
- Shared package ifw_pkg holds:
  - ifw_state encodings (IDLE/FILL/WAIT/DONE).
  - cfg_mast_state labels NORMAL=1, LEFT=2, RIGH=3.
  - Default width constants.
- count_yi_v4 is the natural sub-module: the enable-gated inclusive-final wrap counter with a last flag, instantiated for cnt00, cnt01 and the row counter.

## Test plan
- Basic run:
  - Stimulus: cnt00_final=3, cnt01_final=1, row_final=1, s_valid constant.
  - Response: 8 stg0 pulses to buf0, stg1 pulses on beats 4 and 8; buf0 full; sel=1; 8 beats to buf1.
  - Then DONE, then done; buf_full=2'b11.
- Back-pressure: both buffers full with row_final=3. Response:
  - Enters WAIT with s_ready=0.
  - buf_rd_done=2'b01 leaves sel=0 not targeted, so it stays in WAIT.
  - buf_rd_done=2'b10 gives s_ready=1 two cycles later.
- Clear/set collision: buf_rd_done on the current buffer in the same cycle as its row complete -> buf_full stays 1.
- Zero finals: all finals 0 -> each accept pulses stg0 and stg1 together and completes a row. Two accepts reach DONE when row_final=1.
- Reset mid-row: assert reset after 2 of 4 beats -> next cycle all outputs return to reset values and no enables pulse.
- With IFW_SCHED_PERF_EN: hold s_valid for 5 cycles while in WAIT -> perf_stall_cnt=5.
